pulse_peak_detector: RTL and testbench

- Consumes the shaped stream from the trapezoidal shaping filter, one signed sample per clock, and extracts one record per pulse: peak amplitude, peak timestamp and width above threshold.
- Holds each record in a single-entry valid/ready output register for the readout/histogram stage.
- Applies a hold-off after each pulse to suppress filter ringing.

---
 rtl/pulse_peak_detector.sv | 229 ++++++++++++++++++++++
 tb/tb_pulse_peak_detector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector: extracts one record per pulse (peak amplitude, time of
// first peak sample, width above threshold) from the shaped filter stream.
// Records sit in a single-entry valid/ready output register. A hold-off
// after each pulse suppresses filter ringing.
// Optional build macro PEAK_DET_PILEUP_EN: flags a re-trigger seen during
// hold-off on the next emitted record. Without it peak_pileup is always 0.
module pulse_peak_detector #(
  parameter int DATA_W      = 16,
  parameter int TIME_W      = 32,
  parameter int WIDTH_W     = 16,
  parameter int MIN_WIDTH   = 4,
  parameter int HOLDOFF_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  filter_data,
  input  logic [DATA_W-1:0]  threshold,
  input  logic               out_ready,
  output logic               peak_valid,
  output logic [DATA_W-1:0]  peak_amplitude,
  output logic [TIME_W-1:0]  peak_time,
  output logic [WIDTH_W-1:0] peak_width,
  output logic               peak_pileup,
  output logic [WIDTH_W-1:0] lost_cnt,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int               HC_W      = $clog2(HOLDOFF_LEN + 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLDOFF_LEN - 1);
  localparam logic [WIDTH_W-1:0] W_MAX   = {WIDTH_W{1'b1}};
  localparam logic [WIDTH_W-1:0] W_MIN   = WIDTH_W'(MIN_WIDTH);

  // input stage and timestamp
  logic [DATA_W-1:0]  s_q, s_d;
  logic [TIME_W-1:0]  s_ts_q, s_ts_d;
  logic [TIME_W-1:0]  ts_q, ts_d;
  // pulse tracking
  logic [1:0]         state_q, state_d;
  logic [DATA_W-1:0]  max_q, max_d;
  logic [TIME_W-1:0]  max_t_q, max_t_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  // output register
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  amp_q, amp_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [WIDTH_W-1:0] pw_q, pw_d;
  logic               pile_q, pile_d;
  logic [WIDTH_W-1:0] lost_q, lost_d;
  logic               busy_q, busy_d;

  logic above_s;
  logic emit_s;
  logic pile_rec_s;

  assign above_s = $signed(s_q) > $signed(threshold);

  // Input register: sample, its capture timestamp, free-running counter.
  always_comb begin
    s_d    = filter_data;
    s_ts_d = ts_q;
    ts_d   = ts_q + TIME_W'(1);
  end

  // Pulse FSM: track max/time/width in RISE, enforce hold-off afterwards.
  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    max_t_d    = max_t_q;
    width_d    = width_q;
    hold_cnt_d = hold_cnt_q;
    emit_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (above_s) begin
          state_d = ST_RISE;
          max_d   = s_q;
          max_t_d = s_ts_q;
          width_d = WIDTH_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RISE: begin
        if (above_s) begin
          if (width_q != W_MAX) begin
            width_d = width_q + WIDTH_W'(1);
          end else begin
            width_d = width_q;
          end
          // strict compare: ties keep the earlier timestamp
          if ($signed(s_q) > $signed(max_q)) begin
            max_d   = s_q;
            max_t_d = s_ts_q;
          end else begin
            max_d   = max_q;
          end
        end else if (width_q >= W_MIN) begin
          emit_s     = 1'b1;
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if ((hold_cnt_q >= HOLD_LAST) && !above_s) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q < HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

`ifdef PEAK_DET_PILEUP_EN
  logic prev_above_q;
  logic pile_flag_q, pile_flag_d;

  // Sticky pile-up flag: set on a rising crossing during hold-off, cleared by an emit.
  always_comb begin
    if (emit_s) begin
      pile_flag_d = 1'b0;
    end else if ((state_q == ST_HOLD) && above_s && !prev_above_q) begin
      pile_flag_d = 1'b1;
    end else begin
      pile_flag_d = pile_flag_q;
    end
  end

  // Pile-up state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_above_q <= 1'b0;
      pile_flag_q  <= 1'b0;
    end else begin
      prev_above_q <= above_s;
      pile_flag_q  <= pile_flag_d;
    end
  end

  assign pile_rec_s = pile_flag_q;
`else
  assign pile_rec_s = 1'b0;
`endif

  // Output register: load on emit when free or being accepted, else count a drop.
  always_comb begin
    valid_d = valid_q;
    amp_d   = amp_q;
    time_d  = time_q;
    pw_d    = pw_q;
    pile_d  = pile_q;
    lost_d  = lost_q;
    if (emit_s && (!valid_q || out_ready)) begin
      valid_d = 1'b1;
      amp_d   = max_q;
      time_d  = max_t_q;
      pw_d    = width_q;
      pile_d  = pile_rec_s;
    end else if (emit_s) begin
      if (lost_q != W_MAX) begin
        lost_d = lost_q + WIDTH_W'(1);
      end else begin
        lost_d = lost_q;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // All state registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q        <= '0;
      s_ts_q     <= '0;
      ts_q       <= '0;
      state_q    <= ST_IDLE;
      max_q      <= '0;
      max_t_q    <= '0;
      width_q    <= '0;
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
      amp_q      <= '0;
      time_q     <= '0;
      pw_q       <= '0;
      pile_q     <= 1'b0;
      lost_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      s_q        <= s_d;
      s_ts_q     <= s_ts_d;
      ts_q       <= ts_d;
      state_q    <= state_d;
      max_q      <= max_d;
      max_t_q    <= max_t_d;
      width_q    <= width_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
      amp_q      <= amp_d;
      time_q     <= time_d;
      pw_q       <= pw_d;
      pile_q     <= pile_d;
      lost_q     <= lost_d;
      busy_q     <= busy_d;
    end
  end

  assign peak_valid     = valid_q;
  assign peak_amplitude = amp_q;
  assign peak_time      = time_q;
  assign peak_width     = pw_q;
  assign peak_pileup    = pile_q;
  assign lost_cnt       = lost_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Self-checking bench for pulse_peak_detector: directed scenarios plus
// randomized pulses, checked against a reference computed from the sample lists.
module tb_pulse_peak_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] filter_data;
  logic [15:0] threshold;
  logic        out_ready;
  logic        peak_valid;
  logic [15:0] peak_amplitude;
  logic [31:0] peak_time;
  logic [15:0] peak_width;
  logic        peak_pileup;
  logic [15:0] lost_cnt;
  logic        busy;

  pulse_peak_detector dut (
    .clk(clk), .reset(reset), .filter_data(filter_data), .threshold(threshold),
    .out_ready(out_ready), .peak_valid(peak_valid), .peak_amplitude(peak_amplitude),
    .peak_time(peak_time), .peak_width(peak_width), .peak_pileup(peak_pileup),
    .lost_cnt(lost_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ts_model = 0;
  int valid_cycles = 0;
  logic [15:0] pq[$];
  logic [15:0] exp_amp;
  logic [31:0] exp_time;
  logic [15:0] exp_width;
  logic [15:0] sav_amp;
  logic [31:0] sav_time;
  logic [15:0] sav_width;
  logic        exp_pile;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one sample per clock; outputs sampled 1 time unit after the edge
  task automatic step(input logic [15:0] v);
    filter_data = v;
    @(posedge clk);
    ts_model++;
    #1;
    if (peak_valid) valid_cycles++;
  endtask

  task automatic gap(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // reference: max of the above-threshold run, first index reaching it, count
  task automatic run_pulse(input logic [15:0] fall);
    int base;
    base = ts_model;
    exp_amp = pq[0];
    exp_time = 32'(base);
    for (int i = 1; i < pq.size(); i++) begin
      if ($signed(pq[i]) > $signed(exp_amp)) begin
        exp_amp = pq[i];
        exp_time = 32'(base + i);
      end
    end
    exp_width = (pq.size() > 65535) ? 16'hFFFF : 16'(pq.size());
    for (int i = 0; i < pq.size(); i++) step(pq[i]);
    step(fall);
  endtask

  task automatic gen_pulse(input int len);
    int t;
    t = $signed(threshold);
    pq.delete();
    for (int i = 0; i < len; i++) pq.push_back(16'(t + 1 + int'($urandom_range(0, 2000))));
  endtask

  task automatic check_rec(input string tag, input logic [15:0] a, input logic [31:0] t,
                           input logic [15:0] w);
    check({tag, "_valid"}, {63'd0, peak_valid}, 64'd1);
    check({tag, "_amp"}, {48'd0, peak_amplitude}, {48'd0, a});
    check({tag, "_time"}, {32'd0, peak_time}, {32'd0, t});
    check({tag, "_width"}, {48'd0, peak_width}, {48'd0, w});
  endtask

  initial begin
    reset = 1'b0; filter_data = 16'd0; threshold = 16'd100; out_ready = 1'b1;
`ifdef PEAK_DET_PILEUP_EN
    exp_pile = 1'b1;
`else
    exp_pile = 1'b0;
`endif
    #12;
    check("rst_valid", {63'd0, peak_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_lost", {48'd0, lost_cnt}, 64'd0);
    check("rst_amp", {48'd0, peak_amplitude}, 64'd0);
    check("rst_time", {32'd0, peak_time}, 64'd0);
    check("rst_width", {48'd0, peak_width}, 64'd0);
    check("rst_pile", {63'd0, peak_pileup}, 64'd0);
    @(negedge clk); reset = 1'b1; ts_model = 0;

    // reset in the middle of a pulse
    step(16'd0); step(16'd200); step(16'd300);
    check("midrst_busy_before", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_valid", {63'd0, peak_valid}, 64'd0);
    check("midrst_lost", {48'd0, lost_cnt}, 64'd0);
    @(negedge clk); reset = 1'b1; ts_model = 0;
    valid_cycles = 0;
    gap(30, 16'd0);
    check("midrst_norec", 64'(valid_cycles), 64'd0);

    // basic pulse
    valid_cycles = 0;
    step(16'd0);
    pq = '{16'd150, 16'd400, 16'd900, 16'd900, 16'd600};
    run_pulse(16'd50);
    check("basic_lat1", {63'd0, peak_valid}, 64'd0);
    step(16'd0);
    check_rec("basic", exp_amp, exp_time, exp_width);
    check("basic_amp_const", {48'd0, peak_amplitude}, 64'd900);
    check("basic_pile", {63'd0, peak_pileup}, 64'd0);
    step(16'd0);
    check("basic_accept", {63'd0, peak_valid}, 64'd0);
    check("basic_busy_hold", {63'd0, busy}, 64'd1);
    gap(40, 16'd0);
    check("basic_idle", {63'd0, busy}, 64'd0);
    check("basic_count", 64'(valid_cycles), 64'd1);

    // short pulse is discarded
    valid_cycles = 0;
    pq = '{16'd200, 16'd300, 16'd250};
    run_pulse(16'd0);
    gap(20, 16'd0);
    check("short_norec", 64'(valid_cycles), 64'd0);
    check("short_lost", {48'd0, lost_cnt}, 64'd0);

    // back-pressure: second record dropped
    out_ready = 1'b0;
    gen_pulse(int'($urandom_range(4, 10)));
    run_pulse(16'd0);
    step(16'd0);
    check_rec("bp_a", exp_amp, exp_time, exp_width);
    sav_amp = exp_amp; sav_time = exp_time; sav_width = exp_width;
    gap(25, 16'd0);
    gen_pulse(int'($urandom_range(4, 10)));
    run_pulse(16'd0);
    step(16'd0);
    check_rec("bp_held", sav_amp, sav_time, sav_width);
    check("bp_lost", {48'd0, lost_cnt}, 64'd1);
    out_ready = 1'b1;
    step(16'd0);
    check("bp_handshake", {63'd0, peak_valid}, 64'd0);
    check("bp_lost_after", {48'd0, lost_cnt}, 64'd1);
    gap(30, 16'd0);

    // accept on the same edge as a new emit
    out_ready = 1'b0;
    gen_pulse(int'($urandom_range(4, 10)));
    run_pulse(16'd0);
    step(16'd0);
    check_rec("sim_c", exp_amp, exp_time, exp_width);
    gap(30, 16'd0);
    gen_pulse(int'($urandom_range(4, 10)));
    run_pulse(16'd0);
    out_ready = 1'b1;
    step(16'd0);
    check_rec("sim_d", exp_amp, exp_time, exp_width);
    check("sim_lost", {48'd0, lost_cnt}, 64'd1);
    step(16'd0);
    check("sim_accept", {63'd0, peak_valid}, 64'd0);
    gap(30, 16'd0);

    // randomized pulses with varying thresholds and lengths
    for (int it = 0; it < 10; it++) begin
      int t, len;
      t = int'($urandom_range(0, 500));
      threshold = 16'(t);
      gap(3, 16'(t - 10));
      valid_cycles = 0;
      len = int'($urandom_range(1, 10));
      gen_pulse(len);
      run_pulse(16'(t - int'($urandom_range(0, 3))));
      if (len >= 4) begin
        check("rnd_lat1", {63'd0, peak_valid}, 64'd0);
        step(16'(t - 1));
        check_rec("rnd", exp_amp, exp_time, exp_width);
      end else begin
        step(16'(t - 1));
        check("rnd_short", {63'd0, peak_valid}, 64'd0);
      end
      for (int g = 0; g < 25; g++) step(16'(t - int'($urandom_range(0, 200))));
      check("rnd_count", 64'(valid_cycles), (len >= 4) ? 64'd1 : 64'd0);
    end

    // signed threshold, hold-off suppression and pile-up flag
    threshold = 16'hFFCE; // -50
    gap(20, 16'hFF9C);    // -100
    valid_cycles = 0;
    pq = '{16'hFFD8, 16'hFFE2, 16'hFFEC, 16'hFFF6, 16'hFFEC, 16'hFFE2}; // -40 -30 -20 -10 -20 -30
    run_pulse(16'hFFC4);  // -60
    step(16'hFFC4);
    check_rec("neg", exp_amp, exp_time, exp_width);
    check("neg_amp_const", {48'd0, peak_amplitude}, 64'h0000_0000_0000_FFF6);
    check("neg_width_const", {48'd0, peak_width}, 64'd6);
    check("neg_pile0", {63'd0, peak_pileup}, 64'd0);
    gap(3, 16'hFFC4);
    step(16'hFFD3); step(16'hFFE2); step(16'hFFD3); // -45 -30 -45, inside hold-off
    gap(40, 16'hFFC4);
    check("holdoff_ignored", 64'(valid_cycles), 64'd1);
    pq = '{16'hFFD8, 16'hFFEC, 16'hFFE2, 16'hFFDD}; // -40 -20 -30 -35
    run_pulse(16'hFFC4);
    step(16'hFFC4);
    check_rec("pile", exp_amp, exp_time, exp_width);
    check("pile_flag", {63'd0, peak_pileup}, {63'd0, exp_pile});
    gap(5, 16'hFFC4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
